// File: rtl/ldi_pkg.sv
// ldi_pkg: shared types and constants for the LDI word-alignment controller.
//   lane_state_t : per-lane alignment FSM state
//   SER_FACTOR   : LVDS serialization factor (7 bit positions per word)
//   RUN_W        : width of the de run-length counter
//   slip_inc     : advance a slip position modulo SER_FACTOR
package ldi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_SLIP,
        ST_HOLDOFF,
        ST_LOCKED
    } lane_state_t;

    localparam int SER_FACTOR = 7;
    localparam int RUN_W      = 12;

    function automatic logic [2:0] slip_inc(input logic [2:0] s);
        return (s == 3'(SER_FACTOR - 1)) ? 3'd0 : s + 3'd1;
    endfunction

endpackage

// File: rtl/ldi_align_lane.sv
// ldi_align_lane: word-alignment FSM for one LVDS pixel lane.
//   clock, reset       : pixel clock, asynchronous active-high reset
//   rx_locked          : deserializer PLL lock
//   de                 : lane data enable
//   manual_en/slip/step: manual override (only with LDI_ALIGN_MANUAL_EN)
//   align              : bitslip request
//   locked             : word alignment achieved
//   error              : sticky, a full rotation of slips failed to lock
//   slip_count         : current slip position 0..6
module ldi_align_lane
    import ldi_pkg::*;
#(
    parameter int DE_MIN        = 310,
    parameter int DE_MAX        = 970,
    parameter int LINES_TO_LOCK = 4,
    parameter int LINES_TO_LOSE = 3,
    parameter int HOLDOFF       = 16,
    parameter int TIMEOUT       = 2 ** 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_locked,
    input  logic       de,
`ifdef LDI_ALIGN_MANUAL_EN
    input  logic       manual_en,
    input  logic       manual_slip,
    input  logic       manual_step,
`endif
    output logic       align,
    output logic       locked,
    output logic       error,
    output logic [2:0] slip_count
);

    localparam int GW = $clog2(LINES_TO_LOCK + 1);
    localparam int LW = $clog2(LINES_TO_LOSE + 1);
    localparam int CW = $clog2(HOLDOFF + 1);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [GW-1:0] LOCK_N = GW'(LINES_TO_LOCK);
    localparam logic [LW-1:0] LOSE_N = LW'(LINES_TO_LOSE);

    lane_state_t      state, state_n;
    logic             de_q, have_prev;
    logic [RUN_W-1:0] run;
    logic [RUN_W-2:0] prev_hi;
    logic [GW-1:0]    good_cnt;
    logic [LW-1:0]    loss_cnt;
    logic [CW-1:0]    cnt;
    logic [TW-1:0]    timer;
    logic [2:0]       consec;
    logic             fall, line_ok, timeout, slip_done;

    assign fall      = de_q & ~de;
    // Lines are compared ignoring the LSB so a one-clock jitter in de length
    // does not count as a misalignment.
    assign line_ok   = (run >= RUN_W'(DE_MIN)) && (run <= RUN_W'(DE_MAX)) &&
                       (run[RUN_W-1:1] == prev_hi);
    assign timeout   = timer == TW'(TIMEOUT - 1);
    assign slip_done = (state == ST_SLIP) && (state_n == ST_HOLDOFF);

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:    state_n = rx_locked ? ST_MEASURE : ST_IDLE;
            ST_MEASURE: begin
                if (fall) begin
                    if (have_prev)
                        state_n = !line_ok ? ST_SLIP :
                                  (good_cnt + 1'b1 == LOCK_N) ? ST_LOCKED : ST_MEASURE;
                end else if (timeout) begin
                    state_n = ST_SLIP;
                end
            end
            ST_SLIP:    state_n = (cnt == CW'(1)) ? ST_HOLDOFF : ST_SLIP;
            ST_HOLDOFF: state_n = (cnt == CW'(HOLDOFF - 1)) ? ST_MEASURE : ST_HOLDOFF;
            ST_LOCKED: begin
                if (fall) begin
                    if (!line_ok && (loss_cnt + 1'b1 == LOSE_N)) state_n = ST_SLIP;
                end else if (timeout) begin
                    state_n = ST_SLIP;
                end
            end
            default:    state_n = ST_IDLE;
        endcase
        if (!rx_locked) state_n = ST_IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            de_q       <= 1'b0;
            run        <= '0;
            prev_hi    <= '0;
            have_prev  <= 1'b0;
            good_cnt   <= '0;
            loss_cnt   <= '0;
            cnt        <= '0;
            timer      <= '0;
            consec     <= '0;
            align      <= 1'b0;
            locked     <= 1'b0;
            error      <= 1'b0;
            slip_count <= '0;
        end
`ifdef LDI_ALIGN_MANUAL_EN
        else if (manual_en) begin
            align <= manual_slip;
            if (manual_step) slip_count <= slip_inc(slip_count);
        end
`endif
        else begin
            state <= state_n;
            de_q  <= de;
            run   <= de ? ((&run) ? run : run + 1'b1) : '0;
            // Timeout only runs while a line is expected; any falling edge reloads it.
            timer <= (fall || !(state == ST_MEASURE || state == ST_LOCKED)) ? '0 : timer + 1'b1;
            cnt   <= (state_n != state) ? '0 : cnt + 1'b1;
            if (state == ST_IDLE || state == ST_HOLDOFF) begin
                have_prev <= 1'b0;
                prev_hi   <= '0;
                good_cnt  <= '0;
            end else if (state == ST_MEASURE && fall) begin
                have_prev <= 1'b1;
                prev_hi   <= run[RUN_W-1:1];
                if (have_prev && line_ok) good_cnt <= good_cnt + 1'b1;
            end
            loss_cnt <= (state != ST_LOCKED) ? '0 :
                        fall ? (line_ok ? '0 : loss_cnt + 1'b1) : loss_cnt;
            if (slip_done) begin
                slip_count <= slip_inc(slip_count);
                consec     <= (consec == 3'd7) ? consec : consec + 3'd1;
                error      <= error | (consec == 3'(SER_FACTOR - 1));
            end else if (state_n == ST_LOCKED) begin
                consec <= '0;
            end
            align  <= state_n == ST_SLIP;
            locked <= state_n == ST_LOCKED;
        end
    end

endmodule

// File: rtl/ldi_align_controller.sv
// ldi_align_controller: per-lane LVDS word-alignment controller driving
// rx_channel_data_align from the data-enable run length of each lane.
//   clock, reset     : deserializer pixel clock, asynchronous active-high reset
//   rx_locked        : deserializer PLL lock, shared by all lanes
//   de[P]            : per-lane data enable
//   manual_en        : freeze FSMs, drive align from manual_slip (LDI_ALIGN_MANUAL_EN)
//   manual_slip[P]   : manual bitslip per lane (LDI_ALIGN_MANUAL_EN)
//   align[P]         : bitslip request per lane
//   locked[P]        : alignment achieved per lane
//   error[P]         : sticky, all slip positions tried without lock
//   slip_count[3*P]  : slip position per lane, 3 bits each
// Optional feature macro: LDI_ALIGN_MANUAL_EN
module ldi_align_controller
    import ldi_pkg::*;
#(
    parameter int PIXELS_IN_PARALLEL = 2,
    parameter int DE_MIN             = 310,
    parameter int DE_MAX             = 970,
    parameter int LINES_TO_LOCK      = 4,
    parameter int LINES_TO_LOSE      = 3,
    parameter int HOLDOFF            = 16,
    parameter int TIMEOUT            = 2 ** 20
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            rx_locked,
    input  logic [PIXELS_IN_PARALLEL-1:0]   de,
`ifdef LDI_ALIGN_MANUAL_EN
    input  logic                            manual_en,
    input  logic [PIXELS_IN_PARALLEL-1:0]   manual_slip,
`endif
    output logic [PIXELS_IN_PARALLEL-1:0]   align,
    output logic [PIXELS_IN_PARALLEL-1:0]   locked,
    output logic [PIXELS_IN_PARALLEL-1:0]   error,
    output logic [3*PIXELS_IN_PARALLEL-1:0] slip_count
);

`ifdef LDI_ALIGN_MANUAL_EN
    logic [PIXELS_IN_PARALLEL-1:0] manual_q, manual_step;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) manual_q <= '0;
        else       manual_q <= manual_slip;
    end

    assign manual_step = manual_slip & ~manual_q;
`endif

    for (genvar i = 0; i < PIXELS_IN_PARALLEL; i++) begin : g_lane
        ldi_align_lane #(
            .DE_MIN        (DE_MIN),
            .DE_MAX        (DE_MAX),
            .LINES_TO_LOCK (LINES_TO_LOCK),
            .LINES_TO_LOSE (LINES_TO_LOSE),
            .HOLDOFF       (HOLDOFF),
            .TIMEOUT       (TIMEOUT)
        ) u_lane (
            .clock       (clock),
            .reset       (reset),
            .rx_locked   (rx_locked),
            .de          (de[i]),
`ifdef LDI_ALIGN_MANUAL_EN
            .manual_en   (manual_en),
            .manual_slip (manual_slip[i]),
            .manual_step (manual_step[i]),
`endif
            .align       (align[i]),
            .locked      (locked[i]),
            .error       (error[i]),
            .slip_count  (slip_count[3*i +: 3])
        );
    end

endmodule

// File: tb/tb_ldi_align_controller.sv
// tb_ldi_align_controller: directed self-checking bench for ldi_align_controller.
module tb_ldi_align_controller;
    import ldi_pkg::*;

    localparam int GAP = 24;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx_locked = 1'b0;
    logic [1:0] de = 2'b00;
    logic [1:0] align, locked, error;
    logic [5:0] slip_count;

    int  n_checks = 0;
    int  n_fail = 0;
    int  run_len[2], alt_len[2], ctr[2], cur[2], nline[2], fall_cnt[2], align_cyc[2];
    int  hold1 = 0;
    bit  gen_on[2], alt_on[2];
    int  base, hbase;

    ldi_align_controller dut (
        .clock      (clock),
        .reset      (reset),
        .rx_locked  (rx_locked),
        .de         (de),
        .align      (align),
        .locked     (locked),
        .error      (error),
        .slip_count (slip_count)
    );

    always #5 clock = ~clock;

    // Line generator: de high for cur[l] cycles, then GAP cycles low.
    initial begin
        forever begin
            @(negedge clock);
            for (int l = 0; l < 2; l++) begin
                if (!gen_on[l]) begin
                    de[l] = 1'b0; ctr[l] = 0; nline[l] = 0; fall_cnt[l] = 0;
                end else begin
                    if (ctr[l] == 0) cur[l] = (alt_on[l] && (nline[l] % 2 == 1)) ? alt_len[l] : run_len[l];
                    ctr[l]++;
                    de[l] = ctr[l] <= cur[l];
                    if (ctr[l] == cur[l] + 1) fall_cnt[l]++;
                    if (ctr[l] == cur[l] + GAP) begin ctr[l] = 0; nline[l]++; end
                end
            end
        end
    end

    always @(negedge clock) begin
        for (int l = 0; l < 2; l++) if (align[l]) align_cyc[l]++;
        if (dut.g_lane[1].u_lane.state == ST_HOLDOFF) hold1++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Returns 1ns after the posedge that samples the n-th falling edge of lane l.
    task automatic wait_fall(input int l, input int n);
        int b = 0;
        do begin @(posedge clock); b++; end while (fall_cnt[l] < n && b < 20000);
        #1;
        if (fall_cnt[l] < n) check("timeout_fall", fall_cnt[l], n);
    endtask

    task automatic restart(input int l0, input int l1, input bit alt1);
        gen_on[0] = 0; gen_on[1] = 0;
        rx_locked = 1'b0;
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        run_len[0] = l0; run_len[1] = l1;
        alt_on[0] = 0; alt_on[1] = alt1; alt_len[1] = 820;
        step(1);
        rx_locked = 1'b1;
        step(1);
        gen_on[0] = 1; gen_on[1] = 1;
    endtask

    initial begin
        // Stable 800 on both lanes: lock on the 5th falling edge, no slips.
        gen_on[0] = 0; gen_on[1] = 0;
        step(3);
        reset = 1'b0;
        step(1);
        check("rst_align", align, 2'b00);
        check("rst_locked", locked, 2'b00);
        check("rst_error", error, 2'b00);
        check("rst_slip", slip_count, 6'd0);
        restart(800, 800, 0);
        base = align_cyc[0] + align_cyc[1];
        wait_fall(0, 4);
        check("lock_not_yet", locked, 2'b00);
        wait_fall(0, 5);
        check("lock_5th", locked, 2'b11);
        check("lock_no_align", align_cyc[0] + align_cyc[1] - base, 0);

        // Lane 1 alternates 800/820: one slip of 2 cycles, then 16 HOLDOFF cycles.
        restart(800, 800, 1);
        base = align_cyc[1];
        hbase = hold1;
        wait_fall(1, 2);
        check("alt_align_rise", align, 2'b10);
        step(1);
        check("alt_align_2nd", align, 2'b10);
        step(1);
        check("alt_align_drop", align, 2'b00);
        check("alt_slip1", slip_count[5:3], 3'd1);
        check("alt_align_cyc", align_cyc[1] - base, 2);
        step(20);
        check("alt_holdoff", hold1 - hbase, 16);
        base = align_cyc[0];
        wait_fall(0, 5);
        check("alt_l0_locked", locked[0], 1'b1);
        check("alt_l0_slip", slip_count[2:0], 3'd0);
        check("alt_l0_noalign", align_cyc[0] - base, 0);

        // Lane 0 run 200: slips forever, error on the 7th, position wraps.
        restart(200, 800, 0);
        base = align_cyc[0];
        wait_fall(0, 2);
        check("short_align", align[0], 1'b1);
        wait_fall(0, 12);
        step(2);
        check("short_slip6", slip_count[2:0], 3'd6);
        check("short_err_no", error[0], 1'b0);
        wait_fall(0, 14);
        step(2);
        check("short_slip7", slip_count[2:0], 3'd0);
        check("short_err", error[0], 1'b1);
        wait_fall(0, 16);
        step(2);
        check("short_slip8", slip_count[2:0], 3'd1);
        check("short_err_sticky", error[0], 1'b1);
        check("short_align_cyc", align_cyc[0] - base, 16);
        wait_fall(1, 5);
        check("short_l1_locked", locked[1], 1'b1);
        check("short_l1_err", error[1], 1'b0);

        // Loss of lock: lane 0 gets 3 bad lines, lane 1 gets 2 bad + 1 good.
        restart(800, 800, 0);
        wait_fall(0, 5);
        check("loss_locked", locked, 2'b11);
        run_len[0] = 100; run_len[1] = 100;
        wait_fall(0, 7);
        check("loss_two_bad", locked, 2'b11);
        run_len[1] = 800;
        wait_fall(0, 8);
        check("loss_l0_drop", locked[0], 1'b0);
        check("loss_l0_slip", align[0], 1'b1);
        run_len[0] = 800;
        base = align_cyc[1];
        wait_fall(1, 8);
        check("loss_l1_hold", locked[1], 1'b1);
        wait_fall(1, 9);
        check("loss_l1_hold2", locked[1], 1'b1);
        check("loss_l1_noalign", align_cyc[1] - base, 0);

        // rx_locked drop mid-HOLDOFF: IDLE next cycle, slip position kept.
        restart(200, 800, 0);
        wait_fall(0, 2);
        step(2);
        check("rxl_slip", slip_count[2:0], 3'd1);
        step(5);
        rx_locked = 1'b0;
        step(1);
        check("rxl_idle0", dut.g_lane[0].u_lane.state, ST_IDLE);
        check("rxl_idle1", dut.g_lane[1].u_lane.state, ST_IDLE);
        check("rxl_slip_kept", slip_count[2:0], 3'd1);
        check("rxl_outs", {align, locked}, 4'b0000);

        // Asynchronous reset during SLIP drops align before the next edge.
        restart(200, 800, 0);
        wait_fall(0, 2);
        check("ars_align", align[0], 1'b1);
        #2 reset = 1'b1;
        #1;
        check("ars_drop", align, 2'b00);
        check("ars_state", dut.g_lane[0].u_lane.state, ST_IDLE);
        gen_on[0] = 0; gen_on[1] = 0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
